// File: rtl/apu_rev_counter.sv
`default_nettype none
// ============================================================================
// Module   : apu_rev_counter
// Purpose  : Cascadable up/down counter with reload register, selectable
//            terminal behaviour (wrap/reload/saturate/one-shot) and a
//            registered terminal-count pulse for APU timers and dividers.
// Revision : 1.0 - initial release
// ============================================================================
module apu_rev_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RELOAD_INIT = '0
) (
    input  logic             ACLK1,
    input  logic             res,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             wr_reload,
    input  logic             clear,
    input  logic             step,
    input  logic             cin,
    input  logic             dec,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             tc_pulse,
    output logic             done
);

    localparam logic [1:0] c_MODE_WRAP    = 2'b00;
    localparam logic [1:0] c_MODE_RELOAD  = 2'b01;
    localparam logic [1:0] c_MODE_SAT     = 2'b10;
    localparam logic [1:0] c_MODE_ONESHOT = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;
    logic             r_tc;

    logic             w_terminal;
    logic             w_eff_step;
    logic [WIDTH-1:0] w_q_step;

    // Terminal tracks the live direction so a cascade sees dec changes at once.
    assign w_terminal = dec ? (r_q == '0) : (r_q == '1);
    assign w_eff_step = step & cin & ~r_done;
    assign w_q_step   = dec ? (r_q - WIDTH'(1)) : (r_q + WIDTH'(1));

    always_ff @(posedge ACLK1) begin
        if (res) begin
            r_q      <= '0;
            r_reload <= RELOAD_INIT;
            r_done   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= w_eff_step & w_terminal & ~load & ~clear;

            // Reload register loads independently; a reload taken on this
            // same edge still uses the old value.
            if (wr_reload) begin
                r_reload <= d;
            end

            if (load) begin
                r_q    <= d;
                r_done <= 1'b0;
            end else if (clear) begin
                r_q    <= '0;
                r_done <= 1'b0;
            end else if (w_eff_step) begin
                if (!w_terminal) begin
                    r_q <= w_q_step;
                end else begin
                    case (mode)
                        c_MODE_WRAP:    r_q    <= w_q_step;
                        c_MODE_RELOAD:  r_q    <= r_reload;
                        c_MODE_SAT:     r_q    <= r_q;
                        c_MODE_ONESHOT: r_done <= 1'b1;
                        default:        r_q    <= r_q;
                    endcase
                end
            end
        end
    end

    assign q        = r_q;
    assign cout     = cin & w_terminal;
    assign tc_pulse = r_tc;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_apu_rev_counter.sv
`default_nettype none
// Directed bench for apu_rev_counter: single 8-bit instance plus a
// two-stage 4-bit cascade sharing the clock and reset.
module tb_apu_rev_counter;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [7:0] d = '0;
    logic       load = 1'b0, wr_reload = 1'b0, clear = 1'b0, step = 1'b0;
    logic       cin = 1'b0, dec = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] q;
    logic       cout, tc_pulse, done;

    logic [3:0] c_d_lo = '0, c_d_hi = '0;
    logic       c_load = 1'b0, c_step = 1'b0;
    logic [3:0] c_q_lo, c_q_hi;
    logic       c_cout_lo, c_cout_hi, c_tc_lo, c_tc_hi, c_done_lo, c_done_hi;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apu_rev_counter #(.WIDTH(8), .RELOAD_INIT(8'h3C)) u_dut (
        .ACLK1(clk), .res(res), .d(d), .load(load), .wr_reload(wr_reload),
        .clear(clear), .step(step), .cin(cin), .dec(dec), .mode(mode),
        .q(q), .cout(cout), .tc_pulse(tc_pulse), .done(done)
    );

    apu_rev_counter #(.WIDTH(4), .RELOAD_INIT(4'h0)) u_lo (
        .ACLK1(clk), .res(res), .d(c_d_lo), .load(c_load), .wr_reload(1'b0),
        .clear(1'b0), .step(c_step), .cin(1'b1), .dec(1'b0), .mode(2'b00),
        .q(c_q_lo), .cout(c_cout_lo), .tc_pulse(c_tc_lo), .done(c_done_lo)
    );

    apu_rev_counter #(.WIDTH(4), .RELOAD_INIT(4'h0)) u_hi (
        .ACLK1(clk), .res(res), .d(c_d_hi), .load(c_load), .wr_reload(1'b0),
        .clear(1'b0), .step(c_step), .cin(c_cout_lo), .dec(1'b0), .mode(2'b00),
        .q(c_q_hi), .cout(c_cout_hi), .tc_pulse(c_tc_hi), .done(c_done_hi)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_q(input logic [7:0] v);
        load = 1'b1; d = v; tick(); load = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1; load = 1'b1; d = 8'h55; step = 1'b1; cin = 1'b1;
        tick();
        res = 1'b0; load = 1'b0; step = 1'b0;
        n_checks++;
        if (q !== 8'h00) begin n_errors++; $display("FAIL reset_q got %h exp 00", q); end
        n_checks++;
        if (done !== 1'b0 || tc_pulse !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags got done=%b tc=%b exp 0 0", done, tc_pulse);
        end
        mode = 2'b01; dec = 1'b0;
        load_q(8'hFF);
        step = 1'b1; tick(); step = 1'b0;
        n_checks++;
        if (q !== 8'h3C) begin n_errors++; $display("FAIL reset_reload got %h exp 3C", q); end
    endtask

    task automatic test_autoreload();
        logic [7:0] exp_q [4];
        logic       exp_tc [4];
        logic       exp_co [4];
        exp_q  = '{8'hFE, 8'hFF, 8'h05, 8'h06};
        exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_co = '{1'b0, 1'b1, 1'b0, 1'b0};
        mode = 2'b01; dec = 1'b0; cin = 1'b1;
        wr_reload = 1'b1; d = 8'h05; tick(); wr_reload = 1'b0;
        load_q(8'hFD);
        step = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (q !== exp_q[i] || tc_pulse !== exp_tc[i] || cout !== exp_co[i]) begin
                n_errors++;
                $display("FAIL autoreload[%0d] got q=%h tc=%b cout=%b exp q=%h tc=%b cout=%b",
                         i, q, tc_pulse, cout, exp_q[i], exp_tc[i], exp_co[i]);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_cout_comb();
        load_q(8'hFF);
        dec = 1'b0; cin = 1'b1; #1;
        n_checks++;
        if (cout !== 1'b1) begin n_errors++; $display("FAIL cout_nostep got %b exp 1", cout); end
        cin = 1'b0; #1;
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL cout_cin0 got %b exp 0", cout); end
        cin = 1'b1; dec = 1'b1; #1;
        n_checks++;
        if (cout !== 1'b0) begin n_errors++; $display("FAIL cout_dec_ff got %b exp 0", cout); end
        load_q(8'h00);
        n_checks++;
        if (cout !== 1'b1) begin n_errors++; $display("FAIL cout_dec_00 got %b exp 1", cout); end
    endtask

    task automatic test_down_wrap_sat();
        logic [7:0] exp_w [3];
        logic       exp_tw [3];
        logic       exp_ts [3];
        exp_w  = '{8'h00, 8'hFF, 8'hFE};
        exp_tw = '{1'b0, 1'b1, 1'b0};
        exp_ts = '{1'b0, 1'b1, 1'b1};
        dec = 1'b1; cin = 1'b1; mode = 2'b00;
        load_q(8'h01);
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== exp_w[i] || tc_pulse !== exp_tw[i]) begin
                n_errors++;
                $display("FAIL wrap[%0d] got q=%h tc=%b exp q=%h tc=%b", i, q, tc_pulse, exp_w[i], exp_tw[i]);
            end
        end
        step = 1'b0; mode = 2'b10;
        load_q(8'h01);
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== 8'h00 || tc_pulse !== exp_ts[i]) begin
                n_errors++;
                $display("FAIL sat[%0d] got q=%h tc=%b exp q=00 tc=%b", i, q, tc_pulse, exp_ts[i]);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_q [6];
        logic       exp_d [6];
        logic       exp_t [6];
        exp_q = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        mode = 2'b11; dec = 1'b1; cin = 1'b1;
        load_q(8'h03);
        step = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (q !== exp_q[i] || done !== exp_d[i] || tc_pulse !== exp_t[i]) begin
                n_errors++;
                $display("FAIL oneshot[%0d] got q=%h done=%b tc=%b exp q=%h done=%b tc=%b",
                         i, q, done, tc_pulse, exp_q[i], exp_d[i], exp_t[i]);
            end
        end
        // done survives a mode change and still blocks steps
        mode = 2'b00; tick(); tick();
        n_checks++;
        if (q !== 8'h00 || done !== 1'b1) begin
            n_errors++; $display("FAIL oneshot_modechg got q=%h done=%b exp q=00 done=1", q, done);
        end
        step = 1'b0; mode = 2'b11;
        load_q(8'h07);
        n_checks++;
        if (q !== 8'h07 || done !== 1'b0) begin
            n_errors++; $display("FAIL oneshot_reload got q=%h done=%b exp q=07 done=0", q, done);
        end
        step = 1'b1; tick(); step = 1'b0;
        n_checks++;
        if (q !== 8'h06) begin n_errors++; $display("FAIL oneshot_resume got %h exp 06", q); end
    endtask

    task automatic test_priority();
        mode = 2'b00; dec = 1'b0; cin = 1'b1;
        load_q(8'h10);
        load = 1'b1; clear = 1'b1; step = 1'b1; d = 8'h40;
        tick();
        load = 1'b0;
        n_checks++;
        if (q !== 8'h40 || tc_pulse !== 1'b0) begin
            n_errors++; $display("FAIL prio_load got q=%h tc=%b exp q=40 tc=0", q, tc_pulse);
        end
        tick();
        clear = 1'b0; step = 1'b0;
        n_checks++;
        if (q !== 8'h00) begin n_errors++; $display("FAIL prio_clear got %h exp 00", q); end
        // reset mid one-shot
        mode = 2'b11; dec = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin n_errors++; $display("FAIL prio_oneshot_set got %b exp 1", done); end
        wr_reload = 1'b1; d = 8'h99; tick(); wr_reload = 1'b0;
        res = 1'b1; load = 1'b1; d = 8'h77; tick(); res = 1'b0; load = 1'b0;
        n_checks++;
        if (q !== 8'h00 || done !== 1'b0) begin
            n_errors++; $display("FAIL prio_res got q=%h done=%b exp q=00 done=0", q, done);
        end
        mode = 2'b01; dec = 1'b0;
        load_q(8'hFF);
        step = 1'b1; tick(); step = 1'b0;
        n_checks++;
        if (q !== 8'h3C) begin n_errors++; $display("FAIL prio_res_reload got %h exp 3C", q); end
    endtask

    task automatic test_reload_race();
        mode = 2'b01; dec = 1'b0; cin = 1'b1;
        wr_reload = 1'b1; d = 8'h10; tick(); wr_reload = 1'b0;
        load_q(8'hFF);
        step = 1'b1; wr_reload = 1'b1; d = 8'h22; tick();
        step = 1'b0; wr_reload = 1'b0;
        n_checks++;
        if (q !== 8'h10) begin n_errors++; $display("FAIL race_old got %h exp 10", q); end
        load_q(8'hFF);
        step = 1'b1; tick(); step = 1'b0;
        n_checks++;
        if (q !== 8'h22) begin n_errors++; $display("FAIL race_new got %h exp 22", q); end
    endtask

    task automatic test_cascade();
        logic [7:0] exp_v;
        int         n_bad;
        n_bad = 0;
        c_d_lo = 4'hE; c_d_hi = 4'h0; c_load = 1'b1; tick(); c_load = 1'b0;
        exp_v = 8'h0E;
        c_step = 1'b1;
        for (int i = 0; i < 242; i++) begin
            tick();
            exp_v = exp_v + 8'h01;
            n_checks++;
            if ({c_q_hi, c_q_lo} !== exp_v || c_tc_hi !== (exp_v == 8'h00)) begin
                n_errors++; n_bad++;
                if (n_bad < 5)
                    $display("FAIL cascade[%0d] got v=%h tc_hi=%b exp v=%h tc_hi=%b",
                             i, {c_q_hi, c_q_lo}, c_tc_hi, exp_v, (exp_v == 8'h00));
            end
        end
        c_step = 1'b0;
    endtask

    initial begin
        res = 1'b1; tick(); tick(); res = 1'b0;
        test_reset();
        test_autoreload();
        test_cout_comb();
        test_down_wrap_sat();
        test_oneshot();
        test_priority();
        test_reload_race();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
